// File: rtl/saber_host_driver.sv
// Host-side job sequencer for the Saber core: reset core, load program/data words, start, wait for done, stream results.
// Optional watchdog on the WAIT phase is enabled by defining SABER_HOST_TIMEOUT_EN.

module saber_host_driver #(
  parameter logic [30:0] TIMEOUT_CYCLES = 31'd100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [5:0]  n_prog,
  input  logic [9:0]  n_load,
  input  logic [9:0]  n_read,
  input  logic [9:0]  rd_base,
  input  logic [63:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [63:0] snk_data,
  output logic        snk_valid,
  input  logic        snk_ready,
  output logic [31:0] control_low_word,
  output logic [31:0] control_high_word,
  output logic [31:0] dina_ext_low_word,
  output logic [31:0] dina_ext_high_word,
  input  logic [31:0] dout_ext_low_word,
  input  logic [31:0] dout_ext_high_word,
  input  logic [31:0] status,
  output logic        busy,
  output logic        job_done,
  output logic [30:0] cycles,
  output logic        timeout
);

  localparam int unsigned AW = 10;
  localparam int unsigned PW = 6;
  localparam int unsigned CW = 31;

  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_PROG, S_DATA, S_START, S_WAIT, S_READ, S_FIN
  } state_e;

  typedef enum logic [1:0] {R_ISSUE, R_CAP, R_HOLD} rphase_e;

  state_e        state_q;
  rphase_e       rphase_q;
  logic [PW-1:0] n_prog_q;
  logic [AW-1:0] n_load_q;
  logic [AW-1:0] n_read_q;
  logic [AW-1:0] rd_base_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] rd_cnt_q;
  logic          crst_cnt_q;
  logic [1:0]    ign_q;
  logic [63:0]   snk_data_q;
  logic          snk_valid_q;
  logic [CW-1:0] cycles_q;
  logic          timeout_q;
  logic          wd_hit;

  logic [AW-1:0] addr_d;
  logic [AW-1:0] rd_cnt_d;

  assign addr_d   = addr_q + AW'(1);
  assign rd_cnt_d = rd_cnt_q + AW'(1);

`ifdef SABER_HOST_TIMEOUT_EN
  // Watchdog counts only while parked in WAIT.
  logic [CW-1:0] wd_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != S_WAIT) wd_q <= '0;
    else                          wd_q <= wd_q + CW'(1);
  end

  assign wd_hit  = (wd_q == TIMEOUT_CYCLES - CW'(1));
  assign timeout = timeout_q;
`else
  logic unused_wd_cfg;

  assign wd_hit        = 1'b0;
  assign timeout       = 1'b0;
  assign unused_wd_cfg = ^{TIMEOUT_CYCLES, timeout_q};
`endif

  // Job sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rphase_q    <= R_ISSUE;
      n_prog_q    <= '0;
      n_load_q    <= '0;
      n_read_q    <= '0;
      rd_base_q   <= '0;
      addr_q      <= '0;
      rd_addr_q   <= '0;
      rd_cnt_q    <= '0;
      crst_cnt_q  <= 1'b0;
      ign_q       <= '0;
      snk_data_q  <= '0;
      snk_valid_q <= 1'b0;
      cycles_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            n_prog_q   <= n_prog;
            n_load_q   <= n_load;
            n_read_q   <= n_read;
            rd_base_q  <= rd_base;
            timeout_q  <= 1'b0;
            crst_cnt_q <= 1'b0;
            state_q    <= S_CRST;
          end
        end
        S_CRST: begin
          crst_cnt_q <= 1'b1;
          if (crst_cnt_q) begin
            addr_q  <= '0;
            state_q <= (n_prog_q != '0) ? S_PROG :
                       (n_load_q != '0) ? S_DATA : S_START;
          end
        end
        S_PROG: begin
          if (src_valid) begin
            if (addr_d == AW'(n_prog_q)) begin
              addr_q  <= '0;
              state_q <= (n_load_q != '0) ? S_DATA : S_START;
            end else begin
              addr_q <= addr_d;
            end
          end
        end
        S_DATA: begin
          if (src_valid) begin
            if (addr_d == n_load_q) begin
              addr_q  <= '0;
              state_q <= S_START;
            end else begin
              addr_q <= addr_d;
            end
          end
        end
        S_START: begin
          ign_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // status is registered at the core, so done is untrustworthy for 3 cycles.
          if (ign_q != 2'd3) ign_q <= ign_q + 2'd1;
          if (ign_q == 2'd3 && status[0]) begin
            cycles_q  <= status[31:1];
            rd_addr_q <= rd_base_q;
            rd_cnt_q  <= '0;
            rphase_q  <= R_ISSUE;
            state_q   <= (n_read_q != '0) ? S_READ : S_FIN;
          end else if (wd_hit) begin
            timeout_q <= 1'b1;
            state_q   <= S_FIN;
          end
        end
        S_READ: begin
          case (rphase_q)
            R_ISSUE: rphase_q <= R_CAP;
            R_CAP: begin
              snk_data_q  <= {dout_ext_high_word, dout_ext_low_word};
              snk_valid_q <= 1'b1;
              rphase_q    <= R_HOLD;
            end
            default: begin
              if (snk_ready) begin
                snk_valid_q <= 1'b0;
                rd_addr_q   <= rd_addr_q + AW'(1);
                rphase_q    <= R_ISSUE;
                if (rd_cnt_d == n_read_q) state_q  <= S_FIN;
                else                      rd_cnt_q <= rd_cnt_d;
              end
            end
          endcase
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Core control/data words; the write strobe follows src_valid in the same cycle.
  always_comb begin
    control_low_word   = '0;
    control_high_word  = '0;
    dina_ext_low_word  = '0;
    dina_ext_high_word = '0;
    case (state_q)
      S_CRST:  control_high_word[0] = 1'b1;
      S_START: control_high_word[1] = 1'b1;
      S_PROG, S_DATA: begin
        control_low_word[AW-1:0] = addr_q;
        control_low_word[10]     = src_valid;
        control_low_word[11]     = (state_q == S_PROG);
        dina_ext_low_word        = src_data[31:0];
        dina_ext_high_word       = src_data[63:32];
      end
      S_READ:  control_low_word[AW-1:0] = rd_addr_q;
      default: ;
    endcase
  end

  assign src_ready = (state_q == S_PROG) || (state_q == S_DATA);
  assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign job_done  = (state_q == S_FIN);
  assign snk_data  = snk_data_q;
  assign snk_valid = snk_valid_q;
  assign cycles    = cycles_q;

endmodule
